// File: rtl/fsm_example_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsm_example_pkg
// Description : State codes, hold symbols and next-state / output lookups
//               for the controlled example FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package fsm_example_pkg;

  typedef logic [1:0] fsm_state_t;
  typedef logic [1:0] fsm_sym_t;

  localparam fsm_state_t c_S0 = 2'b00;
  localparam fsm_state_t c_S1 = 2'b01;
  localparam fsm_state_t c_S2 = 2'b10;
  localparam fsm_state_t c_S3 = 2'b11;

  // Transition table of the controlled FSM.
  function automatic fsm_state_t next_state(input fsm_state_t s, input fsm_sym_t x);
    fsm_state_t n;
    n = c_S0;
    case (s)
      c_S0: n = x;
      c_S1: begin
        case (x)
          2'b00:   n = c_S0;
          2'b01:   n = c_S3;
          2'b10:   n = c_S1;
          default: n = c_S3;
        endcase
      end
      c_S2: begin
        case (x)
          2'b00:   n = c_S1;
          2'b01:   n = c_S3;
          2'b10:   n = c_S2;
          default: n = c_S0;
        endcase
      end
      default: begin
        case (x)
          2'b00:   n = c_S1;
          2'b01:   n = c_S0;
          2'b10:   n = c_S0;
          default: n = c_S3;
        endcase
      end
    endcase
    return n;
  endfunction

  // Output of the controlled FSM; it depends on the state only.
  function automatic logic fsm_out(input fsm_state_t s);
    logic o;
    case (s)
      c_S0:    o = 1'b1;
      c_S1:    o = 1'b0;
      c_S2:    o = 1'b1;
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  // Symbol that keeps the controlled FSM parked in its current state.
  function automatic fsm_sym_t hold_sym(input fsm_state_t s);
    fsm_sym_t h;
    case (s)
      c_S0:    h = 2'b00;
      c_S1:    h = 2'b10;
      c_S2:    h = 2'b10;
      default: h = 2'b11;
    endcase
    return h;
  endfunction

  // Lowest symbol moving 'from' to 'to' in one step; 00 when none exists,
  // so callers confirm the result with next_state().
  function automatic fsm_sym_t lowest_sym(input fsm_state_t from, input fsm_state_t to);
    fsm_sym_t sym;
    sym = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (next_state(from, fsm_sym_t'(i)) == to) begin
        sym = fsm_sym_t'(i);
      end
    end
    return sym;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_example_model.sv
`default_nettype none
// ============================================================================
// Module      : fsm_example_model
// Description : Combinational copy of the controlled FSM: given a state and
//               an input symbol, produce the next state and current output.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_example_model
  import fsm_example_pkg::*;
(
  input  fsm_state_t cur_state,
  input  fsm_sym_t   symbol,
  output fsm_state_t nxt_state,
  output logic       out_bit
);

  // Pure table lookup, no state held here.
  always_comb begin
    nxt_state = next_state(cur_state, symbol);
    out_bit   = fsm_out(cur_state);
  end

endmodule
`default_nettype wire

// File: rtl/fsm_steer_driver.sv
`default_nettype none
// ============================================================================
// Module      : fsm_steer_driver
// Description : Steers an external FSM to a requested state by driving the
//               shortest symbol path, mirrors its state, and optionally
//               checks its output against the mirrored expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module fsm_steer_driver
  import fsm_example_pkg::*;
#(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_target,
  output logic       req_ready,
  output logic [1:0] drv_input,
  output logic       drv_active,
  input  logic       fsm_output,
  output logic [1:0] model_state,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] c_IDLE  = 2'b00;
  localparam logic [1:0] c_DRIVE = 2'b01;
  localparam logic [1:0] c_RESP  = 2'b10;

  logic [1:0] r_ctrl;
  fsm_state_t r_model_state;
  fsm_sym_t   r_sym0;
  fsm_sym_t   r_sym1;
  logic       r_two;
  logic       r_idx;
  logic       r_sticky;

  fsm_state_t w_next_state;
  logic       w_exp_out;
  logic       w_mismatch;
  logic       w_accept;
  fsm_sym_t   w_direct_sym;
  logic       w_direct_ok;
  fsm_sym_t   w_first_sym;
  fsm_state_t w_hop_state;
  logic       w_path_out_unused;
  fsm_sym_t   w_second_sym;
  logic       w_len0;
  logic       w_len2;

  // Mirror of the controlled FSM, fed with whatever is being driven.
  fsm_example_model u_mirror (
    .cur_state (r_model_state),
    .symbol    (drv_input),
    .nxt_state (w_next_state),
    .out_bit   (w_exp_out)
  );

  // Path lookup: take the direct symbol if there is one, else head for S0;
  // the hop state tells whether a second symbol (from S0) is needed.
  assign w_direct_sym = lowest_sym(r_model_state, req_target);
  assign w_direct_ok  = (next_state(r_model_state, w_direct_sym) == req_target);
  assign w_first_sym  = w_direct_ok ? w_direct_sym : lowest_sym(r_model_state, c_S0);

  fsm_example_model u_path (
    .cur_state (r_model_state),
    .symbol    (w_first_sym),
    .nxt_state (w_hop_state),
    .out_bit   (w_path_out_unused)
  );

  assign w_second_sym = lowest_sym(w_hop_state, req_target);
  assign w_len0       = (req_target == r_model_state);
  assign w_len2       = !w_len0 && (w_hop_state != req_target);
  assign w_accept     = req_valid && (r_ctrl == c_IDLE);

  generate
    if (CHECK_EN) begin : g_check_on
      assign w_mismatch = (fsm_output != w_exp_out);
    end else begin : g_check_off
      assign w_mismatch = 1'b0;
    end
  endgenerate

  // Drive the next path symbol in DRIVE, otherwise park the FSM in place.
  always_comb begin
    drv_input = hold_sym(r_model_state);
    if (r_ctrl == c_DRIVE) begin
      drv_input = r_idx ? r_sym1 : r_sym0;
    end
  end

  // Mirrored FSM state follows the driven symbol every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_model_state <= c_S0;
    end else begin
      r_model_state <= w_next_state;
    end
  end

  // Controller: latch the path at accept, walk it, then report once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl   <= c_IDLE;
      r_sym0   <= 2'b00;
      r_sym1   <= 2'b00;
      r_two    <= 1'b0;
      r_idx    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      case (r_ctrl)
        c_IDLE: begin
          if (w_accept) begin
            r_sticky <= 1'b0;
            r_sym0   <= w_first_sym;
            r_sym1   <= w_second_sym;
            r_two    <= w_len2;
            r_idx    <= 1'b0;
            r_ctrl   <= w_len0 ? c_RESP : c_DRIVE;
          end
        end
        c_DRIVE: begin
          if (w_mismatch) begin
            r_sticky <= 1'b1;
          end
          if (r_two && !r_idx) begin
            r_idx <= 1'b1;
          end else begin
            r_ctrl <= c_RESP;
          end
        end
        c_RESP:  r_ctrl <= c_IDLE;
        default: r_ctrl <= c_IDLE;
      endcase
    end
  end

  assign req_ready   = (r_ctrl == c_IDLE);
  assign drv_active  = (r_ctrl == c_DRIVE);
  assign done        = (r_ctrl == c_RESP);
  assign err         = done && CHECK_EN && r_sticky;
  assign model_state = r_model_state;

endmodule
`default_nettype wire

// File: tb/tb_fsm_steer_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsm_steer_driver
// Description : Self-checking bench for fsm_steer_driver with a behavioural
//               plant FSM and a brute-force shortest-path reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsm_steer_driver;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_target;
  logic       req_ready;
  logic [1:0] drv_input;
  logic       drv_active;
  logic       fsm_output;
  logic [1:0] model_state;
  logic       done;
  logic       err;

  int n_tests;
  int n_fail;

  logic [1:0] ref_state;
  logic [1:0] plant_state;
  logic       inject;

  fsm_steer_driver #(.CHECK_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_target  (req_target),
    .req_ready   (req_ready),
    .drv_input   (drv_input),
    .drv_active  (drv_active),
    .fsm_output  (fsm_output),
    .model_state (model_state),
    .done        (done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference transition table, written straight from the state diagram.
  function automatic logic [1:0] ref_next(input logic [1:0] s, input logic [1:0] x);
    case ({s, x})
      4'b0000: return 2'd0; 4'b0001: return 2'd1; 4'b0010: return 2'd2; 4'b0011: return 2'd3;
      4'b0100: return 2'd0; 4'b0101: return 2'd3; 4'b0110: return 2'd1; 4'b0111: return 2'd3;
      4'b1000: return 2'd1; 4'b1001: return 2'd3; 4'b1010: return 2'd2; 4'b1011: return 2'd0;
      4'b1100: return 2'd1; 4'b1101: return 2'd0; 4'b1110: return 2'd0; default: return 2'd3;
    endcase
  endfunction

  function automatic logic ref_out(input logic [1:0] s);
    return (s == 2'd0 || s == 2'd2);
  endfunction

  function automatic logic [1:0] ref_hold(input logic [1:0] s);
    case (s)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Shortest path by exhaustive search; lexicographically lowest wins ties.
  task automatic find_path(input logic [1:0] cur, input logic [1:0] tgt,
                           output int len, output logic [1:0] p0, output logic [1:0] p1);
    bit found;
    len = 0; p0 = 2'b00; p1 = 2'b00; found = 0;
    if (cur != tgt) begin
      for (int a = 0; a < 4; a++) begin
        if (!found && ref_next(cur, 2'(a)) == tgt) begin
          found = 1; len = 1; p0 = 2'(a);
        end
      end
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          if (!found && ref_next(ref_next(cur, 2'(a)), 2'(b)) == tgt) begin
            found = 1; len = 2; p0 = 2'(a); p1 = 2'(b);
          end
        end
      end
    end
  endtask

  // Behavioural stand-in for the controlled FSM, reset by the same signal.
  always @(posedge clk or posedge reset) begin
    if (reset) plant_state <= 2'd0;
    else       plant_state <= ref_next(plant_state, drv_input);
  end
  assign fsm_output = ref_out(plant_state) ^ inject;

  // One full request from IDLE; bad selects a drive cycle whose output is corrupted.
  task automatic run_req(input logic [1:0] tgt, input int bad, input bit keep);
    int len;
    logic [1:0] p [2];
    logic [1:0] st;
    find_path(ref_state, tgt, len, p[0], p[1]);
    st = ref_state;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL req_ready_before_accept: got %b want 1", req_ready);
    end
    req_valid = 1'b1;
    req_target = tgt;
    @(posedge clk); #1;
    if (!keep) req_valid = 1'b0; else req_target = 2'($urandom);
    for (int k = 0; k < len; k++) begin
      inject = (k == bad);
      n_tests++;
      if (drv_active !== 1'b1 || drv_input !== p[k] || done !== 1'b0 || model_state !== st) begin
        n_fail++;
        $display("FAIL drive_cycle%0d tgt=%0d: active=%b drv=%b done=%b state=%0d want active=1 drv=%b done=0 state=%0d",
                 k, tgt, drv_active, drv_input, done, model_state, p[k], st);
      end
      n_tests++;
      if (model_state !== plant_state) begin
        n_fail++; $display("FAIL plant_track: model_state=%0d plant=%0d", model_state, plant_state);
      end
      st = ref_next(st, p[k]);
      @(posedge clk); #1;
      inject = 1'b0;
      if (keep) req_target = 2'($urandom);
    end
    n_tests++;
    if (done !== 1'b1 || err !== (bad >= 0 && bad < len) || model_state !== tgt ||
        drv_input !== ref_hold(tgt) || drv_active !== 1'b0) begin
      n_fail++;
      $display("FAIL done_cycle tgt=%0d: done=%b err=%b state=%0d drv=%b active=%b want done=1 err=%b state=%0d drv=%b active=0",
               tgt, done, err, model_state, drv_input, drv_active, (bad >= 0 && bad < len), tgt, ref_hold(tgt));
    end
    ref_state = tgt;
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || req_ready !== 1'b1 || model_state !== tgt || model_state !== plant_state) begin
      n_fail++;
      $display("FAIL after_done tgt=%0d: done=%b ready=%b state=%0d plant=%0d want done=0 ready=1 state=%0d",
               tgt, done, req_ready, model_state, plant_state, tgt);
    end
  endtask

  task automatic idle_cycles(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (drv_input !== ref_hold(ref_state) || drv_active !== 1'b0 || done !== 1'b0 || model_state !== ref_state) begin
        n_fail++;
        $display("FAIL idle_hold: drv=%b active=%b done=%b state=%0d want drv=%b active=0 done=0 state=%0d",
                 drv_input, drv_active, done, model_state, ref_hold(ref_state), ref_state);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req_valid = 1'b0; req_target = 2'b00; inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (model_state !== 2'd0 || drv_input !== 2'b00 || drv_active !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d drv=%b active=%b done=%b err=%b want all zero",
               model_state, drv_input, drv_active, done, err);
    end
    reset = 1'b0;
    ref_state = 2'd0;
    @(posedge clk); #1;
    n_tests++;
    if (req_ready !== 1'b1 || done !== 1'b0 || model_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b done=%b state=%0d want ready=1 done=0 state=0", req_ready, done, model_state);
    end
  endtask

  task automatic test_direct_path;
    run_req(2'd2, -1, 1'b0);
  endtask

  task automatic test_two_step;
    run_req(2'd1, -1, 1'b0);
    run_req(2'd2, -1, 1'b0);
  endtask

  task automatic test_zero_path;
    run_req(2'd3, -1, 1'b0);
    run_req(2'd3, -1, 1'b0);
  endtask

  task automatic test_error_flag;
    run_req(2'd0, -1, 1'b0);
    run_req(2'd2, 0, 1'b0);
    run_req(2'd1, -1, 1'b0);
  endtask

  task automatic test_reset_abort;
    run_req(2'd3, -1, 1'b0);
    req_valid = 1'b1; req_target = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++;
    if (drv_input !== 2'b01 || drv_active !== 1'b1) begin
      n_fail++; $display("FAIL abort_first_sym: drv=%b active=%b want drv=01 active=1", drv_input, drv_active);
    end
    @(posedge clk); #1;
    n_tests++;
    if (drv_input !== 2'b10 || drv_active !== 1'b1) begin
      n_fail++; $display("FAIL abort_second_sym: drv=%b active=%b want drv=10 active=1", drv_input, drv_active);
    end
    reset = 1'b1;
    #1;
    n_tests++;
    if (model_state !== 2'd0 || drv_input !== 2'b00 || drv_active !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_in_reset: state=%0d drv=%b active=%b done=%b want 0 00 0 0", model_state, drv_input, drv_active, done);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    ref_state = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (done !== 1'b0 || req_ready !== 1'b1 || model_state !== 2'd0) begin
        n_fail++;
        $display("FAIL abort_after_release: done=%b ready=%b state=%0d want done=0 ready=1 state=0", done, req_ready, model_state);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_req(2'd1, -1, 1'b1);
    run_req(2'd3, -1, 1'b1);
    run_req(2'd0, -1, 1'b1);
    req_valid = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_random;
    logic [1:0] tgt;
    int bad;
    for (int it = 0; it < 24; it++) begin
      tgt = 2'($urandom_range(0, 3));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      run_req(tgt, bad, 1'($urandom_range(0, 1)));
      req_valid = 1'b0;
      idle_cycles(int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_direct_path();
    test_two_step();
    test_zero_path();
    test_error_flag();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
